// File: rtl/bmem_responder.sv
// bmem_responder: responder end of the burst-memory (bmem) interface.
// Accepts single-cycle 32-byte line reads and 4-beat write bursts into a 64-bit-word backing store.
// Each accepted read returns 4 in-order 64-bit beats, tagged with the line address,
// no earlier than LATENCY cycles after acceptance. Back-to-back lines are returned without a bubble.
// Interface misuse is reported as a one-cycle registered pulse on proto_err_o.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   bmem_addr_i   request byte address (line aligned expected)
//   bmem_read_i   read request, one-cycle pulse per line
//   bmem_write_i  write burst, high for 4 consecutive cycles
//   bmem_wdata_i  write beat data (beat i -> bytes addr+8i .. addr+8i+7)
//   bmem_ready_o  request accepted this cycle when high
//   bmem_raddr_o  line address of the current read beat
//   bmem_rdata_o  read beat data
//   bmem_rvalid_o raddr/rdata valid
//   proto_err_o   one-cycle pulse, one cycle after a protocol violation
`timescale 1ns/1ps
module bmem_responder #(
    parameter int unsigned ADDR_BITS   = 13, // log2 of store size in 64-bit words
    parameter int unsigned LATENCY     = 8,  // acceptance to first beat, >= 2
    parameter int unsigned QUEUE_DEPTH = 4   // outstanding reads, power of 2, >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr_i,
    input  logic        bmem_read_i,
    input  logic        bmem_write_i,
    input  logic [63:0] bmem_wdata_i,
    output logic        bmem_ready_o,
    output logic [31:0] bmem_raddr_o,
    output logic [63:0] bmem_rdata_o,
    output logic        bmem_rvalid_o,
    output logic        proto_err_o
);

    localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned Words = 2 ** ADDR_BITS;
    localparam logic [CntW-1:0] DepthC = CntW'(QUEUE_DEPTH);

    typedef enum logic [2:0] {StIdle, StBeat0, StBeat1, StBeat2, StBeat3} rstate_e;

    // Head is due next cycle; signed difference keeps this correct across counter wrap.
    function automatic logic due_next(input logic [31:0] now, input logic [31:0] due);
        logic [31:0] diff;
        diff = now + 32'd1 - due;
        return !diff[31];
    endfunction

    logic [63:0]           mem_q   [Words];
    logic [31:0]           qaddr_q [QUEUE_DEPTH];
    logic [31:0]           qdue_q  [QUEUE_DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
    logic [CntW-1:0]       count_q, count_d;
    logic [31:0]           cycle_q;
    rstate_e               rstate_q, rstate_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [31:0]           waddr_q, waddr_d;
    logic                  err_q, err_d;

    logic                  push, pop, rvalid, head_due, next_due, wr_en, misaligned;
    logic [1:0]            beat;
    logic [ADDR_BITS-1:0]  rd_word, wr_word;

    assign bmem_ready_o = !rst && (count_q < DepthC);
    assign misaligned   = (bmem_addr_i[4:0] != 5'd0);
    assign nxt_ptr      = rd_ptr_q + PtrW'(1);
    assign head_due     = (count_q != '0) && due_next(cycle_q, qdue_q[rd_ptr_q]);
    assign next_due     = (count_q > CntW'(1)) && due_next(cycle_q, qdue_q[nxt_ptr]);

    // Read response FSM
    always_comb begin
        rstate_d = rstate_q;
        rvalid   = 1'b0;
        pop      = 1'b0;
        beat     = 2'd0;
        unique case (rstate_q)
            StIdle: begin
                if (head_due) rstate_d = StBeat0;
            end
            StBeat0: begin
                rvalid   = 1'b1;
                beat     = 2'd0;
                rstate_d = StBeat1;
            end
            StBeat1: begin
                rvalid   = 1'b1;
                beat     = 2'd1;
                rstate_d = StBeat2;
            end
            StBeat2: begin
                rvalid   = 1'b1;
                beat     = 2'd2;
                rstate_d = StBeat3;
            end
            StBeat3: begin
                rvalid   = 1'b1;
                beat     = 2'd3;
                pop      = 1'b1;
                rstate_d = next_due ? StBeat0 : StIdle;
            end
            default: rstate_d = StIdle;
        endcase
    end

    // Store read is combinational so a write committed at an earlier edge is visible in the beat.
    assign rd_word       = {qaddr_q[rd_ptr_q][ADDR_BITS+2:5], beat};
    assign bmem_rvalid_o = rvalid;
    assign bmem_raddr_o  = rvalid ? qaddr_q[rd_ptr_q] : 32'd0;
    assign bmem_rdata_o  = rvalid ? mem_q[rd_word] : 64'd0;
    assign proto_err_o   = err_q;

    // Request decode, write burst FSM and protocol checks
    always_comb begin
        err_d   = 1'b0;
        push    = 1'b0;
        wr_en   = 1'b0;
        wr_word = '0;
        wcnt_d  = wcnt_q;
        waddr_d = waddr_q;

        if (bmem_read_i) begin
            if (bmem_write_i || !bmem_ready_o || (wcnt_q != 2'd0)) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
                if (misaligned) err_d = 1'b1;
            end
        end

        if (wcnt_q == 2'd0) begin
            if (bmem_write_i && !bmem_read_i && bmem_ready_o) begin
                wr_en   = 1'b1;
                wr_word = {bmem_addr_i[ADDR_BITS+2:5], 2'd0};
                waddr_d = bmem_addr_i;
                wcnt_d  = 2'd1;
                if (misaligned) err_d = 1'b1;
            end
        end else if (!bmem_write_i || bmem_read_i || (bmem_addr_i != waddr_q)) begin
            // Abort: earlier beats stay written, the offending beat is not retried.
            err_d  = 1'b1;
            wcnt_d = 2'd0;
        end else begin
            wr_en   = 1'b1;
            wr_word = {waddr_q[ADDR_BITS+2:5], wcnt_q};
            wcnt_d  = wcnt_q + 2'd1; // wraps to 0 after beat 3
        end
    end

    always_comb begin
        rd_ptr_d = pop ? nxt_ptr : rd_ptr_q;
        wr_ptr_d = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cycle_q  <= '0;
            wcnt_q   <= 2'd0;
            waddr_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            cycle_q  <= cycle_q + 32'd1;
            wcnt_q   <= wcnt_d;
            waddr_q  <= waddr_d;
            err_q    <= err_d;
        end
    end

    // Queue payload and backing store are never cleared.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            qaddr_q[wr_ptr_q] <= {bmem_addr_i[31:5], 5'd0};
            qdue_q[wr_ptr_q]  <= cycle_q + 32'(LATENCY);
        end
        if (!rst && wr_en) begin
            mem_q[wr_word] <= bmem_wdata_i;
        end
    end

endmodule
